// File: rtl/cache_snoop_responder.sv
// rtl/cache_snoop_responder.sv - MOESI snoop responder for one direct-mapped cache
//
// Accepts one bus snoop at a time, reads the cache line's tag/state/data,
// applies the MOESI transition and returns hit/shared/dirty/data.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   snp_valid/snp_ready      snoop handshake; snp_op (0 BusRd, 1 BusRdX,
//                            2 BusUpgr, 3 reserved), snp_addr
//   arr_rd_en/arr_rd_idx     array read request (1-cycle latency)
//   arr_rd_vld/state/tag/data  array read result
//   arr_wr_en/idx/state      line state update
//   rsp_valid/rsp_ready      response handshake
//   rsp_hit/shared/dirty/has_data/data/err  response payload
module cache_snoop_responder #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int OFF_W     = 3,
  parameter int NUM_LINES = 16,
  localparam int IDX_W    = $clog2(NUM_LINES),
  localparam int TAG_W    = ADDR_W - IDX_W - OFF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              snp_valid,
  output logic              snp_ready,
  input  logic [1:0]        snp_op,
  input  logic [ADDR_W-1:0] snp_addr,
  output logic              arr_rd_en,
  output logic [IDX_W-1:0]  arr_rd_idx,
  input  logic              arr_rd_vld,
  input  logic [2:0]        arr_rd_state,
  input  logic [TAG_W-1:0]  arr_rd_tag,
  input  logic [DATA_W-1:0] arr_rd_data,
  output logic              arr_wr_en,
  output logic [IDX_W-1:0]  arr_wr_idx,
  output logic [2:0]        arr_wr_state,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic              rsp_shared,
  output logic              rsp_dirty,
  output logic              rsp_has_data,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  localparam logic [2:0] ST_I = 3'd0;
  localparam logic [2:0] ST_S = 3'd1;
  localparam logic [2:0] ST_E = 3'd2;
  localparam logic [2:0] ST_M = 3'd3;
  localparam logic [2:0] ST_O = 3'd4;

  localparam logic [1:0] OP_RD   = 2'd0;
  localparam logic [1:0] OP_RDX  = 2'd1;
  localparam logic [1:0] OP_UPGR = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_EVAL, S_RESP} state_t;

  state_t state_q, state_d;

  logic [1:0]              op_q;
  logic [ADDR_W-OFF_W-1:0] line_q;   // tag and index; offset is irrelevant to a snoop
  logic [IDX_W-1:0]        idx;
  logic [TAG_W-1:0]        tag;

  logic              hit_q, shared_q, dirty_q, has_data_q, err_q;
  logic [DATA_W-1:0] data_q;

  logic       ev_hit, ev_err, ev_has_data, ev_dirty, ev_shared, ev_wr;
  logic [2:0] ev_ns;

  // Offset bits never select a line; folded here so they are visibly consumed.
  logic unused_off;
  assign unused_off = ^snp_addr[OFF_W-1:0];

  assign idx = line_q[IDX_W-1:0];
  assign tag = line_q[ADDR_W-OFF_W-1:IDX_W];

  assign arr_rd_idx   = idx;
  assign arr_wr_idx   = idx;
  assign arr_wr_state = arr_wr_en ? ev_ns : 3'd0;

  assign rsp_hit      = hit_q;
  assign rsp_shared   = shared_q;
  assign rsp_dirty    = dirty_q;
  assign rsp_has_data = has_data_q;
  assign rsp_data     = data_q;
  assign rsp_err      = err_q;

  // MOESI evaluation on the array read result; only meaningful in S_EVAL.
  always_comb begin
    ev_hit      = arr_rd_vld && (arr_rd_tag == tag) && (arr_rd_state != ST_I);
    ev_err      = 1'b0;
    ev_ns       = arr_rd_state;
    ev_has_data = 1'b0;
    ev_dirty    = 1'b0;
    if (op_q == 2'd3) begin
      ev_err = 1'b1;
    end else if (ev_hit) begin
      case (op_q)
        OP_RD: begin
          case (arr_rd_state)
            ST_M:    begin ev_ns = ST_O; ev_has_data = 1'b1; end
            ST_O:    ev_has_data = 1'b1;
            ST_E:    begin ev_ns = ST_S; ev_has_data = 1'b1; end
            ST_S:    ev_ns = ST_S;
            default: ev_err = 1'b1;
          endcase
        end
        OP_RDX: begin
          case (arr_rd_state)
            ST_M, ST_O: begin ev_ns = ST_I; ev_has_data = 1'b1; ev_dirty = 1'b1; end
            ST_E:       begin ev_ns = ST_I; ev_has_data = 1'b1; end
            ST_S:       ev_ns = ST_I;
            default:    ev_err = 1'b1;
          endcase
        end
        OP_UPGR: begin
          // An upgrade is only legal from a shared copy; M/E holders cannot see one.
          case (arr_rd_state)
            ST_S:    ev_ns = ST_I;
            ST_O:    begin ev_ns = ST_I; ev_dirty = 1'b1; end
            default: ev_err = 1'b1;
          endcase
        end
        default: ev_err = 1'b1;
      endcase
    end
    ev_wr     = ev_hit && !ev_err && (ev_ns != arr_rd_state);
    ev_shared = ev_hit && !ev_err && (ev_ns != ST_I);
  end

  always_comb begin
    state_d   = state_q;
    snp_ready = 1'b0;
    arr_rd_en = 1'b0;
    arr_wr_en = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        snp_ready = 1'b1;
        if (snp_valid) state_d = S_RD;
      end
      S_RD: begin
        arr_rd_en = 1'b1;
        state_d   = S_EVAL;
      end
      S_EVAL: begin
        // Reset in this cycle must not let the state update reach the array.
        arr_wr_en = ev_wr && !rst;
        state_d   = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= 2'd0;
      line_q     <= '0;
      hit_q      <= 1'b0;
      shared_q   <= 1'b0;
      dirty_q    <= 1'b0;
      has_data_q <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && snp_valid) begin
        op_q   <= snp_op;
        line_q <= snp_addr[ADDR_W-1:OFF_W];
      end
      if (state_q == S_EVAL) begin
        hit_q      <= ev_hit;
        shared_q   <= ev_shared;
        dirty_q    <= ev_dirty;
        has_data_q <= ev_has_data;
        err_q      <= ev_err;
        data_q     <= ev_has_data ? arr_rd_data : '0;
      end
    end
  end

endmodule

// File: tb/tb_cache_snoop_responder.sv
// tb/tb_cache_snoop_responder.sv - scoreboard bench for cache_snoop_responder
module tb_cache_snoop_responder;

  localparam int IDX_W = 4;
  localparam int TAG_W = 25;

  localparam logic [2:0] ST_I = 3'd0;
  localparam logic [2:0] ST_S = 3'd1;
  localparam logic [2:0] ST_E = 3'd2;
  localparam logic [2:0] ST_M = 3'd3;
  localparam logic [2:0] ST_O = 3'd4;

  localparam logic [31:0]      ADDR_A = 32'h0009_1A28;
  localparam logic [TAG_W-1:0] TAG_A  = 25'h1234;
  localparam logic [63:0]      DATA_A = 64'hDEAD_BEEF_0000_0001;

  logic             clk = 1'b0;
  logic             rst;
  logic             snp_valid;
  logic             snp_ready;
  logic [1:0]       snp_op;
  logic [31:0]      snp_addr;
  logic             arr_rd_en;
  logic [IDX_W-1:0] arr_rd_idx;
  logic             arr_rd_vld;
  logic [2:0]       arr_rd_state;
  logic [TAG_W-1:0] arr_rd_tag;
  logic [63:0]      arr_rd_data;
  logic             arr_wr_en;
  logic [IDX_W-1:0] arr_wr_idx;
  logic [2:0]       arr_wr_state;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_hit, rsp_shared, rsp_dirty, rsp_has_data, rsp_err;
  logic [63:0]      rsp_data;

  always #5 clk = ~clk;

  cache_snoop_responder dut (
    .clk(clk), .rst(rst),
    .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op), .snp_addr(snp_addr),
    .arr_rd_en(arr_rd_en), .arr_rd_idx(arr_rd_idx), .arr_rd_vld(arr_rd_vld),
    .arr_rd_state(arr_rd_state), .arr_rd_tag(arr_rd_tag), .arr_rd_data(arr_rd_data),
    .arr_wr_en(arr_wr_en), .arr_wr_idx(arr_wr_idx), .arr_wr_state(arr_wr_state),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_shared(rsp_shared), .rsp_dirty(rsp_dirty), .rsp_has_data(rsp_has_data),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Cache array model with 1-cycle read latency.
  logic             mem_vld [16];
  logic [2:0]       mem_st  [16];
  logic [TAG_W-1:0] mem_tag [16];
  logic [63:0]      mem_data[16];

  always @(posedge clk) begin
    if (arr_rd_en) begin
      arr_rd_vld   <= mem_vld[arr_rd_idx];
      arr_rd_state <= mem_st[arr_rd_idx];
      arr_rd_tag   <= mem_tag[arr_rd_idx];
      arr_rd_data  <= mem_data[arr_rd_idx];
    end
    if (arr_wr_en) mem_st[arr_wr_idx] = arr_wr_state;
  end

  typedef struct {
    logic [4:0]       flags;  // hit, shared, dirty, has_data, err
    logic [63:0]      data;
    logic             wr;
    logic [2:0]       wst;
    logic [IDX_W-1:0] idx;
    int               acc;
    int               wcnt0;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] addr);
    exp_t e;
    logic [IDX_W-1:0] i;
    logic [2:0] st, ns;
    logic hit, err, hd, dt;
    i   = addr[6:3];
    st  = mem_st[i];
    hit = mem_vld[i] && (mem_tag[i] == addr[31:7]) && (st != ST_I);
    err = 1'b0; hd = 1'b0; dt = 1'b0; ns = st;
    if (op == 2'd3) err = 1'b1;
    else if (hit) begin
      if (st > ST_O) err = 1'b1;
      else if (op == 2'd0) begin
        if (st == ST_M) begin ns = ST_O; hd = 1'b1; end
        if (st == ST_O) hd = 1'b1;
        if (st == ST_E) begin ns = ST_S; hd = 1'b1; end
      end else if (op == 2'd1) begin
        ns = ST_I;
        hd = (st != ST_S);
        dt = (st == ST_M) || (st == ST_O);
      end else begin
        if (st == ST_M || st == ST_E) err = 1'b1;
        else begin ns = ST_I; dt = (st == ST_O); end
      end
    end
    e.flags = {hit, hit && !err && ns != ST_I, dt, hd, err};
    e.data  = hd ? mem_data[i] : 64'd0;
    e.wr    = hit && !err && ns != st;
    e.wst   = ns;
    e.idx   = i;
    e.acc   = 0;
    e.wcnt0 = 0;
    return e;
  endfunction

  // Write/response monitor: scoreboard consumer.
  int               wr_cnt = 0;
  int               wr_cyc = 0;
  logic [2:0]       wr_st;
  logic [IDX_W-1:0] wr_idx;
  logic             prev_v = 1'b0;
  exp_t             me;

  always @(negedge clk) begin
    if (arr_wr_en) begin
      wr_cnt++;
      wr_cyc = cyc;
      wr_st  = arr_wr_state;
      wr_idx = arr_wr_idx;
    end
    if (rsp_valid && !prev_v) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected rsp_valid=%0b expected no response", rsp_valid);
      end else begin
        me = sb.pop_front();
        checks++;
        if ({rsp_hit, rsp_shared, rsp_dirty, rsp_has_data, rsp_err} !== me.flags) begin
          errors++;
          $display("FAIL rsp_flags got %b expected %b (hit,shared,dirty,has_data,err)",
                   {rsp_hit, rsp_shared, rsp_dirty, rsp_has_data, rsp_err}, me.flags);
        end
        checks++;
        if (rsp_data !== me.data) begin
          errors++;
          $display("FAIL rsp_data got %h expected %h", rsp_data, me.data);
        end
        checks++;
        if (cyc !== me.acc + 3) begin
          errors++;
          $display("FAIL rsp_latency got cycle %0d expected %0d", cyc, me.acc + 3);
        end
        checks++;
        if (wr_cnt - me.wcnt0 !== (me.wr ? 1 : 0)) begin
          errors++;
          $display("FAIL arr_wr_count got %0d expected %0d", wr_cnt - me.wcnt0, me.wr ? 1 : 0);
        end
        if (me.wr) begin
          checks++;
          if (wr_st !== me.wst || wr_idx !== me.idx || wr_cyc !== me.acc + 2) begin
            errors++;
            $display("FAIL arr_wr got state %0d idx %0d cycle %0d expected %0d %0d %0d",
                     wr_st, wr_idx, wr_cyc, me.wst, me.idx, me.acc + 2);
          end
        end
      end
    end
    prev_v = rsp_valid;
  end

  task automatic set_line(input int i, input logic v, input logic [2:0] st,
                          input logic [TAG_W-1:0] t, input logic [63:0] d);
    mem_vld[i] = v; mem_st[i] = st; mem_tag[i] = t; mem_data[i] = d;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] addr, output int acc);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!snp_ready && n < 20) begin @(negedge clk); n++; end
    if (!snp_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout snp_ready got %0b expected 1", snp_ready);
    end
    e = model(op, addr);
    e.acc = cyc; e.wcnt0 = wr_cnt;
    sb.push_back(e);
    snp_op = op; snp_addr = addr; snp_valid = 1'b1; acc = cyc;
    @(negedge clk);
    snp_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || !snp_ready) && n < 30) begin @(negedge clk); n++; end
    if (sb.size() != 0 || !snp_ready) begin
      checks++; errors++;
      $display("FAIL idle_timeout pending %0d expected 0", sb.size());
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; snp_valid = 1'b0; snp_op = 2'd0; snp_addr = 32'd0; rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) set_line(i, 1'b0, ST_I, '0, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (snp_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %0b expected 1", snp_ready);
    end
    checks++;
    if ({rsp_valid, arr_rd_en, arr_wr_en, arr_rd_idx, arr_wr_idx, arr_wr_state} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl got %b expected 0",
               {rsp_valid, arr_rd_en, arr_wr_en, arr_rd_idx, arr_wr_idx, arr_wr_state});
    end
    checks++;
    if ({rsp_hit, rsp_shared, rsp_dirty, rsp_has_data, rsp_err, rsp_data} !== '0) begin
      errors++; $display("FAIL reset_rsp got %h expected 0", rsp_data);
    end
  endtask

  task automatic test_bus_rd();
    int acc;
    set_line(5, 1'b1, ST_M, TAG_A, DATA_A);
    issue(2'd0, ADDR_A, acc);
    wait_idle();
    checks++;
    if (mem_st[5] !== ST_O) begin
      errors++; $display("FAIL bus_rd_state got %0d expected %0d", mem_st[5], ST_O);
    end
    set_line(5, 1'b1, ST_E, TAG_A, DATA_A);
    issue(2'd0, ADDR_A, acc);
    wait_idle();
    set_line(5, 1'b1, ST_S, TAG_A, DATA_A);
    issue(2'd0, ADDR_A, acc);
    wait_idle();
  endtask

  task automatic test_bus_rdx();
    int acc;
    set_line(5, 1'b1, ST_E, TAG_A, DATA_A);
    issue(2'd1, ADDR_A, acc);
    wait_idle();
    checks++;
    if (mem_st[5] !== ST_I) begin
      errors++; $display("FAIL bus_rdx_state got %0d expected %0d", mem_st[5], ST_I);
    end
    set_line(9, 1'b1, ST_M, 25'h1ABCDE, 64'h0123_4567_89AB_CDEF);
    issue(2'd1, {25'h1ABCDE, 4'd9, 3'd5}, acc);
    wait_idle();
  endtask

  task automatic test_miss();
    int acc;
    set_line(5, 1'b1, ST_M, 25'h1235, DATA_A);
    issue(2'd0, ADDR_A, acc);
    wait_idle();
    checks++;
    if (mem_st[5] !== ST_M) begin
      errors++; $display("FAIL miss_state got %0d expected %0d", mem_st[5], ST_M);
    end
    set_line(5, 1'b0, ST_M, TAG_A, DATA_A);
    issue(2'd1, ADDR_A, acc);
    wait_idle();
  endtask

  task automatic test_errors();
    int acc;
    set_line(5, 1'b1, ST_M, TAG_A, DATA_A);
    issue(2'd2, ADDR_A, acc);
    wait_idle();
    issue(2'd3, ADDR_A, acc);
    wait_idle();
    issue(2'd3, {25'h7, 4'd5, 3'd0}, acc);
    wait_idle();
    set_line(5, 1'b1, 3'd6, TAG_A, DATA_A);
    issue(2'd0, ADDR_A, acc);
    wait_idle();
    set_line(5, 1'b1, ST_O, TAG_A, DATA_A);
    issue(2'd2, ADDR_A, acc);
    wait_idle();
    set_line(5, 1'b1, ST_S, TAG_A, DATA_A);
    issue(2'd2, ADDR_A, acc);
    wait_idle();
    checks++;
    if (mem_st[5] !== ST_I) begin
      errors++; $display("FAIL upgr_state got %0d expected %0d", mem_st[5], ST_I);
    end
  endtask

  task automatic test_back_to_back();
    int acc, n;
    logic [68:0] snap;
    exp_t e2;
    set_line(5, 1'b1, ST_M, TAG_A, DATA_A);
    rsp_ready = 1'b0;
    issue(2'd0, ADDR_A, acc);
    n = 0;
    while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
    if (!rsp_valid) begin
      checks++; errors++;
      $display("FAIL hold_timeout rsp_valid got %0b expected 1", rsp_valid);
    end
    snap = {rsp_hit, rsp_shared, rsp_dirty, rsp_has_data, rsp_err, rsp_data};
    snp_op = 2'd1; snp_addr = ADDR_A; snp_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_hit, rsp_shared, rsp_dirty, rsp_has_data, rsp_err, rsp_data} !== snap ||
          snp_ready !== 1'b0 || rsp_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold_stable cycle %0d got ready %0b valid %0b expected 0 1", i,
                 snp_ready, rsp_valid);
      end
    end
    e2 = model(2'd1, ADDR_A);
    e2.wcnt0 = wr_cnt;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (snp_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_handshake got ready %0b valid %0b expected 1 0", snp_ready, rsp_valid);
    end
    e2.acc = cyc;
    sb.push_back(e2);
    @(negedge clk);
    snp_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_eval();
    int acc, w0;
    set_line(5, 1'b1, ST_M, TAG_A, DATA_A);
    issue(2'd0, ADDR_A, acc);
    @(posedge clk);
    #1 rst = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    w0 = wr_cnt;
    checks++;
    if (arr_wr_en !== 1'b0) begin
      errors++; $display("FAIL rst_eval_wr got %0b expected 0", arr_wr_en);
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (snp_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_eval_idle got ready %0b valid %0b expected 1 0", snp_ready, rsp_valid);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (wr_cnt !== w0 || mem_st[5] !== ST_M || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_eval_drop got writes %0d state %0d expected %0d %0d",
               wr_cnt - w0, mem_st[5], 0, ST_M);
    end
    issue(2'd0, ADDR_A, acc);
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_bus_rd();
    test_bus_rdx();
    test_miss();
    test_errors();
    test_back_to_back();
    test_reset_eval();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
